// File: rtl/dm_job_ctrl_if.sv
// ---------------------------------------------------------------------------
// dm_job_ctrl_if
//   Stream bundle between the DataMover job controller and its environment.
//   master : the job controller (drives commands, result ready, output beats)
//   slave  : DataMover / kernel side (drives command ready, results, beat ready)
//
//   mm2s_cmd_*  72-bit MM2S command stream      (controller -> DataMover)
//   s2mm_cmd_*  72-bit S2MM command stream      (controller -> DataMover)
//   res_*       {id,value} kernel result stream (kernel -> controller)
//   s2mm_*      32-bit packed output beat stream with TLAST (controller -> DataMover)
// ---------------------------------------------------------------------------
interface dm_job_ctrl_if #(
    parameter int RES_W = 16,
    parameter int ID_W  = 8
);
    logic              mm2s_cmd_tvalid;
    logic              mm2s_cmd_tready;
    logic [71:0]       mm2s_cmd_tdata;

    logic              s2mm_cmd_tvalid;
    logic              s2mm_cmd_tready;
    logic [71:0]       s2mm_cmd_tdata;

    logic              res_tvalid;
    logic              res_tready;
    logic [RES_W-1:0]  res_tdata;
    logic [ID_W-1:0]   res_id;

    logic [31:0]       s2mm_tdata;
    logic              s2mm_tvalid;
    logic              s2mm_tlast;
    logic              s2mm_tready;

    modport master (
        output mm2s_cmd_tvalid, mm2s_cmd_tdata,
        input  mm2s_cmd_tready,
        output s2mm_cmd_tvalid, s2mm_cmd_tdata,
        input  s2mm_cmd_tready,
        input  res_tvalid, res_tdata, res_id,
        output res_tready,
        output s2mm_tdata, s2mm_tvalid, s2mm_tlast,
        input  s2mm_tready
    );

    modport slave (
        input  mm2s_cmd_tvalid, mm2s_cmd_tdata,
        output mm2s_cmd_tready,
        input  s2mm_cmd_tvalid, s2mm_cmd_tdata,
        output s2mm_cmd_tready,
        output res_tvalid, res_tdata, res_id,
        input  res_tready,
        input  s2mm_tdata, s2mm_tvalid, s2mm_tlast,
        output s2mm_tready
    );
endinterface

// File: rtl/dm_job_ctrl.sv
// ---------------------------------------------------------------------------
// dm_job_ctrl
//   DataMover job controller for streaming accelerator kernels. A job starts
//   when the PS writes START_CODE to GPIO (and the controller is re-armed by a
//   prior zero write). It issues one MM2S and one S2MM command, then packs
//   RESULT_WORDS {id,value} results into 32-bit output beats with TLAST on the
//   final one. Writing zero aborts a running job or acknowledges a finished one.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   gpio_io_i  PS control word (START_CODE = start, 0 = clear/abort)
//   gpio_io_o  status {count[23:0], tag[3:0], s2mm_cmd_ok, mm2s_cmd_ok, done, busy}
//   bus        command, result and output streams (master side)
// ---------------------------------------------------------------------------
module dm_job_ctrl #(
    parameter int unsigned MM2S_BTT     = 312000,
    parameter logic [31:0] MM2S_ADDR    = 32'h6000_0000,
    parameter int unsigned S2MM_BTT     = 19200,
    parameter logic [31:0] S2MM_ADDR    = 32'h7000_0000,
    parameter int unsigned RESULT_WORDS = 4800,
    parameter int          RES_W        = 16,
    parameter int          ID_W         = 8,
    parameter logic [31:0] START_CODE   = 32'h0000_00AA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   gpio_io_i,
    output logic [31:0]   gpio_io_o,
    dm_job_ctrl_if.master bus
);

    localparam logic [23:0] RW_C = 24'(RESULT_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic        armed;
    logic        done;
    logic        mm2s_ok, s2mm_ok;
    logic        mm2s_vld, s2mm_vld;
    logic        abort_pend;
    logic [3:0]  tag;
    logic [23:0] count;
    logic        out_valid;
    logic        out_last;
    logic [31:0] out_data;

    logic        gpio_clear;
    logic        start;
    logic        res_ready;
    logic        mm2s_hs, s2mm_hs;
    logic        cmds_done;
    logic        res_fire;
    logic        beat_fire;

    // Command word: BTT, INCR, EOF, DRR, address, tag; all reserved bits zero.
    function automatic logic [71:0] cmd_word(input logic [22:0] btt,
                                             input logic [31:0] addr,
                                             input logic [3:0]  t);
        return {4'b0000, t, addr, 1'b1, 1'b1, 6'b000000, 1'b1, btt};
    endfunction

    assign gpio_clear = (gpio_io_i == 32'h0);
    assign mm2s_hs    = mm2s_vld && bus.mm2s_cmd_tready;
    assign s2mm_hs    = s2mm_vld && bus.s2mm_cmd_tready;
    // Both commands are accepted once neither has a handshake still pending,
    // which covers either order as well as both in the same cycle.
    assign cmds_done  = (!mm2s_vld || bus.mm2s_cmd_tready) &&
                        (!s2mm_vld || bus.s2mm_cmd_tready);
    assign res_fire   = bus.res_tvalid && res_ready;
    assign beat_fire  = out_valid && bus.s2mm_tready;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next = state;
        start      = 1'b0;
        res_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gpio_io_i == START_CODE && armed) begin
                    state_next = ST_CMD;
                    start      = 1'b1;
                end
            end
            ST_CMD: begin
                // An abort seen during CMD waits for the command handshakes.
                if (cmds_done) state_next = (abort_pend || gpio_clear) ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                res_ready = !gpio_clear && (count < RW_C) && (!out_valid || bus.s2mm_tready);
                if (beat_fire && out_last)
                    state_next = ST_DONE;
                else if (gpio_clear && (!out_valid || beat_fire))
                    state_next = ST_IDLE;
            end
            ST_DONE: begin
                if (gpio_clear) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed      <= 1'b1;
            done       <= 1'b0;
            mm2s_ok    <= 1'b0;
            s2mm_ok    <= 1'b0;
            mm2s_vld   <= 1'b0;
            s2mm_vld   <= 1'b0;
            abort_pend <= 1'b0;
            tag        <= 4'd0;
            count      <= 24'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= 32'h0;
        end else begin
            // Re-arming on zero means a held START_CODE can only start one job.
            if (gpio_clear) armed <= 1'b1;
            else if (start) armed <= 1'b0;

            if (start) begin
                done       <= 1'b0;
                count      <= 24'd0;
                mm2s_ok    <= 1'b0;
                s2mm_ok    <= 1'b0;
                mm2s_vld   <= 1'b1;
                s2mm_vld   <= 1'b1;
                abort_pend <= 1'b0;
            end

            if (mm2s_hs) begin
                mm2s_vld <= 1'b0;
                mm2s_ok  <= 1'b1;
            end
            if (s2mm_hs) begin
                s2mm_vld <= 1'b0;
                s2mm_ok  <= 1'b1;
            end
            if (state == ST_CMD && gpio_clear) abort_pend <= 1'b1;

            // Output register: loads on accept, otherwise holds until drained.
            if (res_fire) begin
                out_data <= 32'({bus.res_id, bus.res_tdata});
                out_last <= (count == RW_C - 24'd1);
                count    <= count + 24'd1;
            end
            if (res_fire)       out_valid <= 1'b1;
            else if (beat_fire) out_valid <= 1'b0;

            if (state == ST_RUN && state_next == ST_DONE) begin
                done <= 1'b1;
                tag  <= tag + 4'd1;
            end
        end
    end

    // Command data reads zero while idle so all outputs are zero after reset.
    assign bus.mm2s_cmd_tvalid = mm2s_vld;
    assign bus.mm2s_cmd_tdata  = mm2s_vld ? cmd_word(23'(MM2S_BTT), MM2S_ADDR, tag) : 72'h0;
    assign bus.s2mm_cmd_tvalid = s2mm_vld;
    assign bus.s2mm_cmd_tdata  = s2mm_vld ? cmd_word(23'(S2MM_BTT), S2MM_ADDR, tag) : 72'h0;

    assign bus.res_tready  = res_ready;
    assign bus.s2mm_tvalid = out_valid;
    assign bus.s2mm_tdata  = out_data;
    assign bus.s2mm_tlast  = out_last;

    assign gpio_io_o = {count, tag, s2mm_ok, mm2s_ok, done,
                        (state == ST_CMD || state == ST_RUN)};

endmodule
